// File: rtl/frame_writer_pkg.sv
// Shared frame-memory geometry, colour depth and fill-FSM state encoding.
// Every block that addresses the frame buffer imports these definitions.
package frame_writer_pkg;

  localparam int SCR_WIDTH        = 160;
  localparam int SCR_HEIGHT       = 120;
  localparam int SCR_WIDTH_BITS   = 8;
  localparam int SCR_HEIGHT_BITS  = 7;
  localparam int COLOR_SIZE       = 3;
  localparam int MEMORY_SIZE_BITS = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/frame_writer_coor_to_offset.sv
// Combinational (x, y) -> linear frame-memory offset, y * SCR_WIDTH + x.
// The 160-wide screen uses shift-and-add so no multiplier is built.
module coor_to_offset #(
  parameter int SCR_WIDTH = frame_writer_pkg::SCR_WIDTH
) (
  input  logic [frame_writer_pkg::SCR_WIDTH_BITS-1:0]   x,
  input  logic [frame_writer_pkg::SCR_HEIGHT_BITS-1:0]  y,
  output logic [frame_writer_pkg::MEMORY_SIZE_BITS-1:0] offset
);
  import frame_writer_pkg::*;

  logic [MEMORY_SIZE_BITS-1:0] x_ext;
  logic [MEMORY_SIZE_BITS-1:0] y_ext;

  assign x_ext = MEMORY_SIZE_BITS'(x);
  assign y_ext = MEMORY_SIZE_BITS'(y);

  generate
    if (SCR_WIDTH == 160) begin : g_shift_add
      // 160 = 128 + 32
      assign offset = (y_ext << 7) + (y_ext << 5) + x_ext;
    end else begin : g_generic
      assign offset = MEMORY_SIZE_BITS'(y_ext * MEMORY_SIZE_BITS'(SCR_WIDTH)) + x_ext;
    end
  endgenerate

endmodule

// File: rtl/frame_writer.sv
// Rectangle fill engine: latches a clipped rectangle and streams one
// frame-memory write per cycle in raster order, then hands off via out_cont_signal.
module frame_writer #(
  parameter int SCR_WIDTH  = frame_writer_pkg::SCR_WIDTH,
  parameter int SCR_HEIGHT = frame_writer_pkg::SCR_HEIGHT
) (
  input  logic                                          Clck,
  input  logic                                          Reset,
  input  logic                                          in_cont_signal,
  input  logic                                          next_fin_signal,
  input  logic [frame_writer_pkg::SCR_WIDTH_BITS-1:0]   rect_x,
  input  logic [frame_writer_pkg::SCR_HEIGHT_BITS-1:0]  rect_y,
  input  logic [7:0]                                    rect_w,
  input  logic [6:0]                                    rect_h,
  input  logic [frame_writer_pkg::COLOR_SIZE-1:0]       rect_color,
  output logic [frame_writer_pkg::MEMORY_SIZE_BITS-1:0] write_addr,
  output logic [frame_writer_pkg::COLOR_SIZE-1:0]       write_data,
  output logic                                          write_en,
  output logic                                          out_cont_signal
);
  import frame_writer_pkg::*;

  localparam int XW = SCR_WIDTH_BITS;
  localparam int YW = SCR_HEIGHT_BITS;
  localparam logic [XW:0] X_LIM = (XW+1)'(SCR_WIDTH);
  localparam logic [YW:0] Y_LIM = (YW+1)'(SCR_HEIGHT);

  state_t                      state_q, state_d;
  logic [XW-1:0]               x_co_q, x_co_d, x_start_q, x_start_d, x_end_q, x_end_d;
  logic [YW-1:0]               y_co_q, y_co_d, y_end_q, y_end_d;
  logic [COLOR_SIZE-1:0]       color_q, color_d;
  logic [MEMORY_SIZE_BITS-1:0] write_addr_q, write_addr_d, next_offset;
  logic [COLOR_SIZE-1:0]       write_data_q, write_data_d;
  logic                        write_en_q, write_en_d;
  logic                        out_cont_q, out_cont_d;

  // Sums carry one extra bit so a far-right/bottom rectangle cannot wrap.
  logic [XW:0] x_sum;
  logic [YW:0] y_sum;
  logic        empty_rect, last_x, last_y;

  assign x_sum      = {1'b0, rect_x} + {1'b0, rect_w};
  assign y_sum      = {1'b0, rect_y} + {1'b0, rect_h};
  assign empty_rect = (rect_w == '0) || (rect_h == '0) ||
                      ({1'b0, rect_x} >= X_LIM) || ({1'b0, rect_y} >= Y_LIM);
  assign last_x     = (x_co_q == x_end_q - 1'b1);
  assign last_y     = (y_co_q == y_end_q - 1'b1);

  // The address is formed from the coordinate about to be written, so it
  // lands in the output register together with write_en.
  coor_to_offset #(.SCR_WIDTH(SCR_WIDTH)) u_coor_to_offset (
    .x      (x_co_d),
    .y      (y_co_d),
    .offset (next_offset)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    x_co_d       = x_co_q;
    y_co_d       = y_co_q;
    x_start_d    = x_start_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    color_d      = color_q;
    write_en_d   = 1'b0;
    write_addr_d = '0;
    write_data_d = '0;
    out_cont_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_cont_signal) begin
          x_co_d    = rect_x;
          y_co_d    = rect_y;
          x_start_d = rect_x;
          x_end_d   = (x_sum > X_LIM) ? XW'(SCR_WIDTH)  : x_sum[XW-1:0];
          y_end_d   = (y_sum > Y_LIM) ? YW'(SCR_HEIGHT) : y_sum[YW-1:0];
          color_d   = rect_color;
          if (empty_rect) begin
            state_d    = DONE;
            out_cont_d = 1'b1;
          end else begin
            state_d      = WRITE;
            write_en_d   = 1'b1;
            write_addr_d = next_offset;
            write_data_d = rect_color;
          end
        end
      end
      WRITE: begin
        if (last_x && last_y) begin
          state_d    = DONE;
          out_cont_d = 1'b1;
        end else begin
          if (last_x) begin
            x_co_d = x_start_q;
            y_co_d = y_co_q + 1'b1;
          end else begin
            x_co_d = x_co_q + 1'b1;
          end
          write_en_d   = 1'b1;
          write_addr_d = next_offset;
          write_data_d = color_q;
        end
      end
      DONE: begin
        if (next_fin_signal) begin
          state_d = IDLE;
        end else begin
          out_cont_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state_q      <= IDLE;
      x_co_q       <= '0;
      y_co_q       <= '0;
      x_start_q    <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      color_q      <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      out_cont_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_co_q       <= x_co_d;
      y_co_q       <= y_co_d;
      x_start_q    <= x_start_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      color_q      <= color_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      out_cont_q   <= out_cont_d;
    end
  end

  assign write_en        = write_en_q;
  assign write_addr      = write_addr_q;
  assign write_data      = write_data_q;
  assign out_cont_signal = out_cont_q;

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter SCR_WIDTH, default 160, meaning screen width in pixels.
REQ-002 SHALL have parameter SCR_HEIGHT, default 120, meaning screen height in pixels.
REQ-003 SHALL have port Clck  input  1  system clock; all logic acts on the rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_cont_signal  input  1  start continuation; level, sampled only in IDLE.
REQ-006 SHALL have port next_fin_signal  input  1  downstream continuation finished; releases DONE.
REQ-007 SHALL have port rect_x  input  SCR_WIDTH_BITS (8)  rectangle left column.
REQ-008 SHALL have port rect_y  input  SCR_HEIGHT_BITS (7)  rectangle top row.
REQ-009 SHALL have port rect_w  input  8  rectangle width in pixels.
REQ-010 SHALL have port rect_h  input  7  rectangle height in pixels.
REQ-011 SHALL have port rect_color  input  COLOR_SIZE (3)  fill colour.
REQ-012 SHALL have port write_addr  output  MEMORY_SIZE_BITS (15)  frame-memory write address.
REQ-013 SHALL have port write_data  output  COLOR_SIZE (3)  frame-memory write data.
REQ-014 SHALL have port write_en  output  1  one-cycle write strobe per pixel.
REQ-015 SHALL have port out_cont_signal  output  1  fill complete; next continuation may start.

Function
REQ-016 SHALL implement states IDLE, WRITE, DONE; all outputs registered.
REQ-017 In IDLE with in_cont_signal=1: latch rect_x/y/w/h/color, set x_co=rect_x, y_co=rect_y, go to WRITE; inputs are ignored after the latch.
REQ-018 SHALL clip: x_end=min(rect_x+rect_w, SCR_WIDTH), y_end=min(rect_y+rect_h, SCR_HEIGHT); sums are computed one bit wider so they cannot overflow.
REQ-019 If rect_w=0, rect_h=0, rect_x>=SCR_WIDTH or rect_y>=SCR_HEIGHT, SHALL go directly to DONE with zero writes.
REQ-020 In WRITE, SHALL issue exactly one write per cycle: write_en=1, write_data=latched colour, write_addr=y_co*SCR_WIDTH+x_co.
REQ-021 Pixel order: raster; x_co increments; at x_end-1 it wraps to rect_x and y_co increments.
REQ-022 First write_en SHALL appear the cycle after acceptance; total writes = clipped_w*clipped_h, back-to-back with no gaps.
REQ-023 After the write at (x_end-1, y_end-1), write_en SHALL drop and out_cont_signal SHALL rise on the next cycle (state DONE).
REQ-024 In DONE, out_cont_signal SHALL hold 1 until next_fin_signal=1 is sampled; it then clears and the block returns to IDLE.
REQ-025 SHALL ignore in_cont_signal in WRITE and DONE; if it is still high after return to IDLE, a new fill starts (level-triggered re-run).
REQ-026 Address SHALL be computed as (y<<7)+(y<<5)+x for SCR_WIDTH=160, with no multiplier, in 15 bits.
REQ-027 write_addr and write_data SHALL be 0 whenever write_en=0.

Reset
REQ-028 When Reset=0 is sampled, the block SHALL go to IDLE and set write_en=0, write_addr=0, write_data=0, out_cont_signal=0, x_co=0, y_co=0 at that edge.
REQ-029 Reset during WRITE SHALL abort the fill; no write_en on any later cycle until a new acceptance.
REQ-030 Reset SHALL take priority over in_cont_signal and next_fin_signal on the same edge.

Structure
REQ-031 SCR_WIDTH, SCR_HEIGHT, SCR_WIDTH_BITS, SCR_HEIGHT_BITS, COLOR_SIZE and MEMORY_SIZE_BITS SHALL come from the shared header, together with the state encodings.
REQ-032 Address arithmetic SHALL be one combinational sub-module, coor_to_offset, so screenFlash and other frame-memory users can reuse it.

Verification
REQ-033 Rect (10,5,3,2), colour 3'b101, in_cont=1 -> 6 consecutive writes at addresses 810,811,812,970,971,972 with data 5, then out_cont=1 on the next cycle.
REQ-034 Rect (158,119,10,10) -> exactly 2 writes, at 19198 and 19199; then DONE.
REQ-035 rect_w=0, or rect_x=160 -> no write_en; out_cont=1 one cycle after acceptance.
REQ-036 In DONE, hold next_fin=0 for 20 cycles -> out_cont stays 1; pulse next_fin=1 with in_cont still high -> out_cont clears, IDLE, re-accept next cycle.
REQ-037 Reset=0 on the 4th write of a full-screen fill -> write_en=0 from that edge onward; all outputs 0; IDLE.
REQ-038 Change rect inputs during WRITE -> addresses and data follow the latched values only.
